// File: rtl/ux607_spislaveport.sv
// ux607_spislaveport: SPI mode-0 slave port running on the system clock.
// SCK/CS_N/MOSI are sampled from the pads through 3-flop synchronizers, and
// the SPI edges are detected in the clock domain. Received bytes come out
// as a one-cycle rx_valid pulse. The next transmit byte is taken from a
// valid/ready port at CS fall and at each byte boundary.
//
// Ports:
//   clock, reset            system clock, async active-high reset
//   io_pins_*_i_ival        raw pad inputs (SCK, CS_N, MOSI, MISO readback)
//   io_pins_*_o_*           pad controls (constants except MISO oval/oe)
//   tx_valid/tx_data        next byte to transmit
//   tx_ready                combinational, high in cycles where tx_shift loads
//   rx_valid/rx_data        received byte, one-cycle pulse, no backpressure
//   tx_underrun             one-cycle pulse when IDLE_TX had to be loaded
//   busy                    high while the port is selected
module ux607_spislaveport #(
    parameter logic [7:0] IDLE_TX = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       io_pins_sck_i_ival,
    input  logic       io_pins_cs_0_i_ival,
    input  logic       io_pins_dq_0_i_ival,
    input  logic       io_pins_dq_1_i_ival,

    output logic       io_pins_sck_o_oval,
    output logic       io_pins_sck_o_oe,
    output logic       io_pins_sck_o_ie,
    output logic       io_pins_sck_o_pue,
    output logic       io_pins_sck_o_ds,
    output logic       io_pins_cs_0_o_oval,
    output logic       io_pins_cs_0_o_oe,
    output logic       io_pins_cs_0_o_ie,
    output logic       io_pins_cs_0_o_pue,
    output logic       io_pins_cs_0_o_ds,
    output logic       io_pins_dq_0_o_oval,
    output logic       io_pins_dq_0_o_oe,
    output logic       io_pins_dq_0_o_ie,
    output logic       io_pins_dq_0_o_pue,
    output logic       io_pins_dq_0_o_ds,
    output logic       io_pins_dq_1_o_oval,
    output logic       io_pins_dq_1_o_oe,
    output logic       io_pins_dq_1_o_ie,
    output logic       io_pins_dq_1_o_pue,
    output logic       io_pins_dq_1_o_ds,

    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       tx_underrun,
    output logic       busy
);

    localparam int unsigned SYNC_W = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // MISO readback is not needed by this block.
    logic unused_miso_readback;
    assign unused_miso_readback = io_pins_dq_1_i_ival;

    // Fixed pad configuration: SCK/CS/MOSI are inputs, MISO is an output.
    assign io_pins_sck_o_oval  = 1'b0;
    assign io_pins_sck_o_oe    = 1'b0;
    assign io_pins_sck_o_ie    = 1'b1;
    assign io_pins_sck_o_pue   = 1'b0;
    assign io_pins_sck_o_ds    = 1'b0;
    assign io_pins_cs_0_o_oval = 1'b0;
    assign io_pins_cs_0_o_oe   = 1'b0;
    assign io_pins_cs_0_o_ie   = 1'b1;
    assign io_pins_cs_0_o_pue  = 1'b1;
    assign io_pins_cs_0_o_ds   = 1'b0;
    assign io_pins_dq_0_o_oval = 1'b0;
    assign io_pins_dq_0_o_oe   = 1'b0;
    assign io_pins_dq_0_o_ie   = 1'b1;
    assign io_pins_dq_0_o_pue  = 1'b1;
    assign io_pins_dq_0_o_ds   = 1'b0;
    assign io_pins_dq_1_o_ie   = 1'b0;
    assign io_pins_dq_1_o_pue  = 1'b0;
    assign io_pins_dq_1_o_ds   = 1'b1;

    logic [SYNC_W-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_W-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_W-1:0] mosi_sync_q, mosi_sync_d;
    logic              sck_q, sck_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              load_pend_q, load_pend_d;
    logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise_c, sck_fall_c, load_c;

    assign sck_s  = sck_sync_q[SYNC_W-1];
    assign cs_s   = cs_sync_q[SYNC_W-1];
    assign mosi_s = mosi_sync_q[SYNC_W-1];

    assign sck_rise_c = sck_s & ~sck_q;
    assign sck_fall_c = ~sck_s & sck_q;

    // Synchronizers and SCK edge history.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_W-2:0], io_pins_sck_i_ival};
        cs_sync_d   = {cs_sync_q[SYNC_W-2:0], io_pins_cs_0_i_ival};
        mosi_sync_d = {mosi_sync_q[SYNC_W-2:0], io_pins_dq_0_i_ival};
        sck_d       = sck_s;
    end

    // Next-state, shift registers and load control.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        load_pend_d   = load_pend_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        tx_shift_d    = tx_shift_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        load_c        = 1'b0;

        // cs_s only reflects the pad once the synchronizer has refilled after
        // reset; a transfer may start only after CS has been seen high, so a
        // reset in the middle of a CS window never resumes mid-byte.
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd3) & cs_s);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                    load_c      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // CS high wins over any simultaneous SCK edge.
                if (cs_s) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                end else if (sck_rise_c) begin
                    rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        rx_data_d   = {rx_shift_q[BYTE_W-2:0], mosi_s};
                        rx_valid_d  = 1'b1;
                        load_pend_d = 1'b1;
                    end
                end else if (sck_fall_c) begin
                    if (load_pend_q) begin
                        load_c      = 1'b1;
                        load_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            tx_shift_d    = tx_valid ? tx_data : IDLE_TX;
            tx_underrun_d = ~tx_valid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_q         <= 1'b0;
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            load_pend_q   <= 1'b0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            tx_shift_q    <= IDLE_TX;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_q         <= sck_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            load_pend_q   <= load_pend_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            tx_shift_q    <= tx_shift_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign busy                = (state_q == ST_ACTIVE);
    assign tx_ready            = load_c;
    assign rx_valid            = rx_valid_q;
    assign rx_data             = rx_data_q;
    assign tx_underrun         = tx_underrun_q;
    assign io_pins_dq_1_o_oval = tx_shift_q[BYTE_W-1];
    assign io_pins_dq_1_o_oe   = busy;

endmodule

// File: tb/tb_ux607_spislaveport.sv
// Bench for ux607_spislaveport: a mode-0 SPI master model drives the pads with
// SCK = clock/8; expected received bytes go into a queue that a separate
// monitor pops on every rx_valid pulse.
module tb_ux607_spislaveport;

    logic       clock = 1'b0;
    logic       reset;
    logic       sck, cs, mosi, miso_in;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    logic sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
    logic cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;
    logic dq0_oval, dq0_oe, dq0_ie, dq0_pue, dq0_ds;
    logic miso, miso_oe, dq1_ie, dq1_pue, dq1_ds;

    ux607_spislaveport #(.IDLE_TX(8'hFF)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_pins_sck_i_ival  (sck),
        .io_pins_cs_0_i_ival (cs),
        .io_pins_dq_0_i_ival (mosi),
        .io_pins_dq_1_i_ival (miso_in),
        .io_pins_sck_o_oval  (sck_oval),
        .io_pins_sck_o_oe    (sck_oe),
        .io_pins_sck_o_ie    (sck_ie),
        .io_pins_sck_o_pue   (sck_pue),
        .io_pins_sck_o_ds    (sck_ds),
        .io_pins_cs_0_o_oval (cs_oval),
        .io_pins_cs_0_o_oe   (cs_oe),
        .io_pins_cs_0_o_ie   (cs_ie),
        .io_pins_cs_0_o_pue  (cs_pue),
        .io_pins_cs_0_o_ds   (cs_ds),
        .io_pins_dq_0_o_oval (dq0_oval),
        .io_pins_dq_0_o_oe   (dq0_oe),
        .io_pins_dq_0_o_ie   (dq0_ie),
        .io_pins_dq_0_o_pue  (dq0_pue),
        .io_pins_dq_0_o_ds   (dq0_ds),
        .io_pins_dq_1_o_oval (miso),
        .io_pins_dq_1_o_oe   (miso_oe),
        .io_pins_dq_1_o_ie   (dq1_ie),
        .io_pins_dq_1_o_pue  (dq1_pue),
        .io_pins_dq_1_o_ds   (dq1_ds),
        .tx_valid            (tx_valid),
        .tx_data             (tx_data),
        .tx_ready            (tx_ready),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .tx_underrun         (tx_underrun),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int unf_cnt = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counters and rx scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (tx_ready)    ready_cnt++;
            if (tx_underrun) unf_cnt++;
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %02h, expected no rx_valid", rx_data);
                end else begin
                    exp_rx = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(exp_rx));
                end
            end
        end
    end

    task automatic clear_counts();
        ready_cnt = 0;
        unf_cnt   = 0;
        rx_cnt    = 0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic gap();
        repeat (12) @(negedge clock);
    endtask

    // Shift nbits of mo MSB first; MISO is sampled right before each rise.
    // With last set, CS rises together with the final SCK fall.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic last,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = mo[7-k];
            repeat (2) @(negedge clock);
            mi[7-k] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clock);
            sck = 1'b0;
            if (last && k == nbits - 1) cs = 1'b1;
            repeat (2) @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] mi, mi2;

    initial begin
        reset = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; miso_in = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clock);

        // Reset state and pad constants
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_oe", 32'(miso_oe), 0);
        check("rst_miso", 32'(miso), 1);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_underrun", 32'(tx_underrun), 0);
        check("pad_consts", 32'({sck_ie, sck_pue, cs_pue, dq0_pue, dq1_ie, dq1_ds, sck_oe, cs_oe}),
              32'(8'b1_0_1_1_0_1_0_0));

        reset = 1'b0;
        gap();

        // Single byte
        clear_counts();
        tx_valid = 1'b1; tx_data = 8'hA5;
        cs_low();
        check("t1_busy", 32'(busy), 1);
        check("t1_oe", 32'(miso_oe), 1);
        exp_q.push_back(8'h3C);
        xfer(8'h3C, 8, 1'b1, mi);
        gap();
        check("t1_miso", 32'(mi), 32'h A5);
        check("t1_rx_cnt", 32'(rx_cnt), 1);
        check("t1_ready_cnt", 32'(ready_cnt), 1);
        check("t1_unf_cnt", 32'(unf_cnt), 0);
        check("t1_busy_end", 32'(busy), 0);

        // Underrun
        clear_counts();
        tx_valid = 1'b0;
        cs_low();
        exp_q.push_back(8'h96);
        xfer(8'h96, 8, 1'b1, mi);
        gap();
        check("t2_miso", 32'(mi), 32'hFF);
        check("t2_unf_cnt", 32'(unf_cnt), 1);
        check("t2_ready_cnt", 32'(ready_cnt), 1);
        check("t2_rx_cnt", 32'(rx_cnt), 1);

        // Back-to-back bytes in one CS window
        clear_counts();
        tx_valid = 1'b1; tx_data = 8'h12;
        cs_low();
        tx_data = 8'h34;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        xfer(8'hC3, 8, 1'b0, mi);
        xfer(8'h5A, 8, 1'b1, mi2);
        gap();
        check("t3_miso0", 32'(mi), 32'h12);
        check("t3_miso1", 32'(mi2), 32'h34);
        check("t3_rx_cnt", 32'(rx_cnt), 2);
        check("t3_ready_cnt", 32'(ready_cnt), 2);
        check("t3_unf_cnt", 32'(unf_cnt), 0);

        // Abort after 5 bits, then a full byte
        clear_counts();
        tx_data = 8'h77;
        cs_low();
        xfer(8'hF0, 5, 1'b0, mi);
        cs = 1'b1;
        repeat (4) @(negedge clock);
        check("t4_busy", 32'(busy), 0);
        check("t4_oe", 32'(miso_oe), 0);
        check("t4_partial_miso", 32'(mi[7:3]), 32'(5'b01110));
        gap();
        check("t4_rx_cnt", 32'(rx_cnt), 0);
        tx_data = 8'h5C;
        cs_low();
        exp_q.push_back(8'h81);
        xfer(8'h81, 8, 1'b1, mi);
        gap();
        check("t4_miso", 32'(mi), 32'h5C);
        check("t4_rx_cnt2", 32'(rx_cnt), 1);

        // Reset after 3 bits with CS held low
        tx_data = 8'h3A;
        cs_low();
        xfer(8'hE7, 3, 1'b0, mi);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rx_data", 32'(rx_data), 0);
        check("t5_rx_valid", 32'(rx_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_oe", 32'(miso_oe), 0);
        check("t5_miso", 32'(miso), 1);
        check("t5_tx_ready", 32'(tx_ready), 0);
        reset = 1'b0;
        clear_counts();
        xfer(8'hE7, 8, 1'b0, mi);
        gap();
        check("t5_rx_cnt", 32'(rx_cnt), 0);
        check("t5_busy_held", 32'(busy), 0);
        check("t5_ready_cnt", 32'(ready_cnt), 0);
        cs = 1'b1;
        gap();
        tx_data = 8'h6B;
        cs_low();
        exp_q.push_back(8'h24);
        xfer(8'h24, 8, 1'b1, mi);
        gap();
        check("t5_miso", 32'(mi), 32'h6B);
        check("t5_rx_cnt2", 32'(rx_cnt), 1);

        // SCK noise with CS high
        clear_counts();
        for (int n = 0; n < 10; n++) begin
            mosi = n[0];
            sck = 1'b1;
            repeat (4) @(negedge clock);
            sck = 1'b0;
            repeat (4) @(negedge clock);
            if (n == 5) check("t6_oe", 32'(miso_oe), 0);
        end
        gap();
        check("t6_rx_cnt", 32'(rx_cnt), 0);
        check("t6_busy", 32'(busy), 0);
        tx_data = 8'hC9;
        cs_low();
        exp_q.push_back(8'h5A);
        xfer(8'h5A, 8, 1'b1, mi);
        gap();
        check("t6_miso", 32'(mi), 32'hC9);
        check("t6_rx_cnt2", 32'(rx_cnt), 1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
